char_ram_arbiter: RTL and testbench

Owns the single-port character RAM: 64 columns × 16 rows, 8-bit codes, address = {row[3:0], col[5:0]}. Interleaves three users in the px_clk domain:
- display fetch slots, derived from the sync generator's hc/vc counters;
- a terminal-side CPU read/write port;
- a hardware screen-clear engine.

Fetched codes go to the font/shift-register stage. Hardware scroll offset is applied to the display rows only.

---
 rtl/char_ram_arbiter.sv | 134 +++++++++++++
 tb/tb_char_ram_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/char_ram_arbiter.sv
// Character RAM arbiter: display fetch slots, a CPU port and a screen-clear
// engine share one single-port 64x16 character RAM in the px_clk domain.
module char_ram_arbiter #(
  parameter int          HSTART = 112,
  parameter int          VSTART = 145,
  parameter int          COLS   = 64,
  parameter int          ROWS   = 16,
  parameter int          CHAR_H = 16,
  parameter int          LEAD   = 8,
  parameter logic [7:0]  FILL   = 8'h20
) (
  input  logic        px_clk,
  input  logic        clr,
  input  logic [10:0] hc,
  input  logic [10:0] vc,
  input  logic [3:0]  scroll_row,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [9:0]  cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_gnt,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_rvalid,
  input  logic        clear_req,
  output logic        clear_busy,
  output logic [9:0]  ram_addr,
  output logic        ram_we,
  output logic [7:0]  ram_wdata,
  input  logic [7:0]  ram_rdata,
  output logic [7:0]  char_code,
  output logic        char_load,
  output logic [3:0]  row_in_char
);

  localparam int FSTART = HSTART - LEAD;
  localparam int FEND   = FSTART + COLS * 8;
  localparam int VEND   = VSTART + ROWS * CHAR_H;

  typedef enum logic {C_IDLE, C_RUN} clr_state_t;

  clr_state_t  state, state_nx;
  logic [9:0]  ccnt, ccnt_nx;
  logic [3:0]  srow;
  logic        disp_rd_q, cpu_rd_q;

  // Fetch window decode: f counts from the first fetch cycle of the line.
  logic [10:0] f, vrel, trow_w;
  logic        h_win, v_win, slot;
  logic [3:0]  disp_row;

  assign f        = hc - 11'(FSTART);
  assign vrel     = vc - 11'(VSTART);
  assign trow_w   = vrel / 11'(CHAR_H);
  assign h_win    = (hc >= 11'(FSTART)) && (hc < 11'(FEND));
  assign v_win    = (vc >= 11'(VSTART)) && (vc < 11'(VEND));
  assign slot     = h_win && v_win && (f[2:0] == 3'd0);
  assign disp_row = trow_w[3:0] + srow;

  assign row_in_char = v_win ? vrel[3:0] : 4'd0;
  assign clear_busy  = (state == C_RUN);
  assign cpu_gnt     = cpu_req && !slot && !clear_busy;

  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nx = state;
    ccnt_nx  = ccnt;
    unique case (state)
      C_IDLE: begin
        if (clear_req) begin
          state_nx = C_RUN;
          ccnt_nx  = 10'd0;
        end
      end
      C_RUN: begin
        if (!slot) begin
          ccnt_nx = ccnt + 10'd1;
          if (ccnt == 10'd1023) state_nx = C_IDLE;
        end
      end
      default: state_nx = C_IDLE;
    endcase
  end

  // RAM port mux: display slot > clear engine > CPU; idle parks on the CPU address.
  always_comb begin
    ram_addr  = cpu_addr;
    ram_we    = 1'b0;
    ram_wdata = cpu_wdata;
    if (slot) begin
      ram_addr = {disp_row, f[8:3]};
    end else if (clear_busy) begin
      ram_addr  = ccnt;
      ram_we    = 1'b1;
      ram_wdata = FILL;
    end else if (cpu_gnt) begin
      ram_we = cpu_we;
    end
  end

  // NOTE: all state below updates with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge px_clk or posedge clr) begin
    if (clr) begin
      state <= C_IDLE;
      ccnt  <= 10'd0;
      srow  <= 4'd0;
    end else begin
      state <= state_nx;
      ccnt  <= ccnt_nx;
      if (hc == 11'd0 && vc == 11'd0) srow <= scroll_row;
    end
  end

  // Read-return tags: stage 1 marks the cycle ram_rdata is valid, stage 2 lands it.
  always_ff @(posedge px_clk or posedge clr) begin
    if (clr) begin
      disp_rd_q  <= 1'b0;
      cpu_rd_q   <= 1'b0;
      char_code  <= 8'd0;
      char_load  <= 1'b0;
      cpu_rdata  <= 8'd0;
      cpu_rvalid <= 1'b0;
    end else begin
      disp_rd_q  <= slot;
      cpu_rd_q   <= cpu_gnt && !cpu_we;
      char_load  <= disp_rd_q;
      cpu_rvalid <= cpu_rd_q;
      if (disp_rd_q) char_code <= ram_rdata;
      if (cpu_rd_q)  cpu_rdata <= ram_rdata;
    end
  end

endmodule

// File: tb/tb_char_ram_arbiter.sv
// Directed bench for char_ram_arbiter: drives hc/vc directly, models the RAM,
// and checks fetch, CPU, scroll and clear behaviour against hand values.
module tb_char_ram_arbiter;

  logic        px_clk = 1'b0;
  logic        clr;
  logic [10:0] hc, vc;
  logic [3:0]  scroll_row;
  logic        cpu_req, cpu_we;
  logic [9:0]  cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_gnt;
  logic [7:0]  cpu_rdata;
  logic        cpu_rvalid;
  logic        clear_req;
  logic        clear_busy;
  logic [9:0]  ram_addr;
  logic        ram_we;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;
  logic [7:0]  char_code;
  logic        char_load;
  logic [3:0]  row_in_char;
  logic        ram_init;

  int total = 0;
  int bad   = 0;

  char_ram_arbiter dut (
    .px_clk(px_clk), .clr(clr), .hc(hc), .vc(vc), .scroll_row(scroll_row),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .clear_req(clear_req), .clear_busy(clear_busy),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .char_code(char_code), .char_load(char_load), .row_in_char(row_in_char)
  );

  always #5 px_clk = ~px_clk;

  function automatic logic [7:0] init_val(input int i);
    logic [31:0] t;
    t = i * 7 + 65;
    if (i == 5) return 8'h7E;
    return t[7:0];
  endfunction

  function automatic bit is_slot(input int h, input int v);
    return (h >= 104) && (h < 616) && (v >= 145) && (v < 401) && (((h - 104) % 8) == 0);
  endfunction

  // Single-port synchronous RAM: read data valid the cycle after its address.
  logic [7:0] mem [1024];
  always @(posedge px_clk) begin
    if (ram_init) begin
      for (int i = 0; i < 1024; i++) mem[i] <= init_val(i);
    end else begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (hc=%0d vc=%0d)", tag, got, exp, hc, vc);
    end
  endtask

  task automatic step();
    @(posedge px_clk); #1;
    if (hc == 11'd800) begin
      hc = 11'd0;
      vc = (vc == 11'd525) ? 11'd0 : vc + 11'd1;
    end else begin
      hc = hc + 11'd1;
    end
    #1;
  endtask

  task automatic goto(input int h, input int v);
    @(posedge px_clk); #1;
    hc = 11'(h);
    vc = 11'(v);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, cycles, slots, gnt_seen, we_in_slot, wrong, guard;

    clr = 1'b1; ram_init = 1'b1;
    hc = 11'd0; vc = 11'd0; scroll_row = 4'd0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 10'h3AA; cpu_wdata = 8'h00;
    clear_req = 1'b0;
    repeat (2) @(posedge px_clk);
    #2 ram_init = 1'b0;
    #1;
    check("rst_char_code",  char_code,  8'h00);
    check("rst_char_load",  char_load,  1'b0);
    check("rst_cpu_rdata",  cpu_rdata,  8'h00);
    check("rst_cpu_rvalid", cpu_rvalid, 1'b0);
    check("rst_clear_busy", clear_busy, 1'b0);
    check("rst_ram_we",     ram_we,     1'b0);
    check("rst_row_in_char", row_in_char, 4'd0);
    #2 clr = 1'b0;
    step();

    // One full display line at vc=145, scroll 0.
    goto(100, 145);
    check("row_in_char_145", row_in_char, 4'd0);
    for (int n = 0; n < 530; n++) begin
      int h;
      h = int'(hc);
      if (is_slot(h, 145)) begin
        check("disp_addr", ram_addr, (h - 104) / 8);
        check("disp_we",   ram_we,   1'b0);
      end
      if (h >= 106 && h < 618 && ((h - 106) % 8) == 0) begin
        check("disp_load", char_load, 1'b1);
        check("disp_code", char_code, init_val((h - 106) / 8));
      end else if (h >= 106 && h < 620) begin
        check("disp_noload", char_load, 1'b0);
      end
      if (h == 616) check("no_fetch_616", ram_addr, 10'h3AA);
      step();
    end
    goto(0, 150);
    check("row_in_char_150", row_in_char, 4'd5);
    goto(800, 525);
    check("no_fetch_term", ram_addr, 10'h3AA);

    // CPU request on a display slot, then reads around the fetch pipeline.
    goto(104, 145);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'd5; #1;
    check("gnt_in_slot", cpu_gnt, 1'b0);
    check("slot_addr",   ram_addr, 10'd0);
    step();
    check("gnt_after_slot", cpu_gnt, 1'b1);
    check("cpu_rd_addr",    ram_addr, 10'd5);
    step();
    cpu_req = 1'b0; #1;
    check("b2b_load",   char_load,  1'b1);
    check("b2b_code",   char_code,  8'h41);
    check("b2b_rv0",    cpu_rvalid, 1'b0);
    step();
    check("b2b_rvalid", cpu_rvalid, 1'b1);
    check("b2b_rdata",  cpu_rdata,  8'h7E);
    check("b2b_load0",  char_load,  1'b0);
    repeat (4) step();
    cpu_req = 1'b1; cpu_addr = 10'd5; #1;
    check("gnt_ph7", cpu_gnt, 1'b1);
    step();
    cpu_req = 1'b0; #1;
    check("addr_112", ram_addr, 10'd1);
    step();
    check("rvalid_113", cpu_rvalid, 1'b1);
    check("rdata_113",  cpu_rdata,  8'h7E);
    check("load_113",   char_load,  1'b0);
    step();
    check("load_114",   char_load,  1'b1);
    check("code_114",   char_code,  init_val(1));
    check("rvalid_114", cpu_rvalid, 1'b0);

    // Sustained CPU writes across the start of the fetch window.
    goto(100, 145);
    cpu_req = 1'b1; cpu_we = 1'b1; k = 0;
    for (int n = 0; n < 24; n++) begin
      int h;
      h = int'(hc);
      cpu_addr = 10'(640 + k); cpu_wdata = 8'(8'h90 + k); #1;
      check("sus_gnt", cpu_gnt, !is_slot(h, 145));
      if (h == 106 || h == 114 || h == 122)
        check("sus_code", char_code, init_val((h - 106) / 8));
      if (cpu_gnt) k++;
      step();
    end
    cpu_req = 1'b0; cpu_addr = 10'h3AA;
    step();
    check("sus_count", k, 21);
    wrong = 0;
    for (int i = 0; i < 21; i++) if (mem[640 + i] !== 8'(8'h90 + i)) wrong++;
    check("sus_data", wrong, 0);

    // Scroll changed mid-frame takes effect only at the next hc=0/vc=0.
    goto(100, 150);
    scroll_row = 4'd15;
    repeat (4) step();
    check("scroll_hold_150", ram_addr, 10'd0);
    goto(104, 161);
    check("scroll_hold_161", ram_addr, 10'd64);
    goto(0, 0);
    step();
    goto(104, 145);
    check("scroll_addr_145", ram_addr, 10'd960);
    step(); step();
    check("scroll_code_145", char_code, init_val(960));
    goto(104, 161);
    check("scroll_wrap_161", ram_addr, 10'd0);
    goto(104, 400);
    check("scroll_last_row", ram_addr, 10'd896);
    goto(104, 401);
    check("below_window", ram_addr, 10'h3AA);
    scroll_row = 4'd0;
    goto(0, 0);
    step();

    // Clear requested together with a CPU write during blanking.
    goto(0, 10);
    clear_req = 1'b1; cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 10'd3; cpu_wdata = 8'h99; #1;
    check("sim_gnt",  cpu_gnt,    1'b1);
    check("sim_busy", clear_busy, 1'b0);
    check("sim_addr", ram_addr,   10'd3);
    step();
    clear_req = 1'b0; cpu_we = 1'b0; cpu_addr = 10'd7; #1;
    check("clr_busy0", clear_busy, 1'b1);
    check("clr_addr0", ram_addr,   10'd0);
    check("clr_we0",   ram_we,     1'b1);
    check("clr_data0", ram_wdata,  8'h20);
    cycles = 0; gnt_seen = 0;
    while (clear_busy && cycles < 3000) begin
      if (cpu_gnt) gnt_seen++;
      cycles++;
      step();
    end
    check("clr_cycles", cycles, 1024);
    check("clr_no_gnt", gnt_seen, 0);
    check("clr_gnt_after", cpu_gnt, 1'b1);
    cpu_req = 1'b0;
    wrong = 0;
    for (int i = 0; i < 1024; i++) if (mem[i] !== 8'h20) wrong++;
    check("clr_fill", wrong, 0);

    // Clear spanning active lines stretches by one cycle per display slot.
    goto(400, 145);
    clear_req = 1'b1; #1;
    step();
    clear_req = 1'b0; #1;
    cycles = 0; slots = 0; we_in_slot = 0;
    while (clear_busy && cycles < 3000) begin
      if (is_slot(int'(hc), int'(vc))) begin
        slots++;
        if (ram_we) we_in_slot++;
      end
      cycles++;
      step();
    end
    check("span_slots",  slots,      90);
    check("span_cycles", cycles,     1114);
    check("span_we",     we_in_slot, 0);

    // Abort a clear with clr, then restart from address 0.
    goto(0, 10);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 10'd1023; cpu_wdata = 8'h5A; #1;
    step();
    cpu_addr = 10'd0; #1;
    step();
    cpu_req = 1'b0; cpu_we = 1'b0;
    goto(400, 144);
    clear_req = 1'b1; #1;
    step();
    clear_req = 1'b0; #1;
    guard = 0;
    while (!(hc == 11'd106 && vc == 11'd145) && guard < 2000) begin
      step();
      guard++;
    end
    check("abort_reached", guard < 2000, 1'b1);
    check("abort_pre_busy", clear_busy, 1'b1);
    check("abort_pre_load", char_load,  1'b1);
    #1 clr = 1'b1;
    #1;
    check("abort_busy",   clear_busy, 1'b0);
    check("abort_load",   char_load,  1'b0);
    check("abort_rvalid", cpu_rvalid, 1'b0);
    check("abort_code",   char_code,  8'h00);
    @(posedge px_clk);
    #3 clr = 1'b0;
    check("abort_mem0",    mem[0],    8'h20);
    check("abort_mem1023", mem[1023], 8'h5A);
    goto(0, 20);
    clear_req = 1'b1; #1;
    step();
    clear_req = 1'b0; #1;
    check("restart_busy", clear_busy, 1'b1);
    check("restart_addr", ram_addr,   10'd0);
    check("restart_we",   ram_we,     1'b1);
    cycles = 0;
    while (clear_busy && cycles < 3000) begin
      cycles++;
      step();
    end
    check("restart_cycles", cycles, 1024);
    check("restart_mem1023", mem[1023], 8'h20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
